// File: rtl/mvm_pkg.sv
// Shared constants, state encodings and width helpers for the matrix-vector multiply engine.
package mvm_pkg;

  localparam int unsigned DEF_NROW  = 16;
  localparam int unsigned DEF_NCOL  = 4;
  localparam int unsigned DEF_NLANE = 4;
  localparam int unsigned DEF_QN    = 6;
  localparam int unsigned DEF_QM    = 11;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Address width that never collapses to zero bits.
  function automatic int unsigned aw(input int unsigned v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

  localparam int unsigned BW    = DEF_QN + DEF_QM + 1;
  localparam int unsigned ACC_W = 2 * BW + clog2(DEF_NCOL);
  localparam int unsigned P     = DEF_NROW / DEF_NLANE;
  localparam int unsigned PW    = aw(P);
  localparam int unsigned CW    = aw(DEF_NCOL);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mvm_if.sv
// Handshake, memory-read and result bus of mvm_engine; slave = engine side.
interface mvm_if
  import mvm_pkg::*;
#(
  parameter int unsigned NROW  = DEF_NROW,
  parameter int unsigned NCOL  = DEF_NCOL,
  parameter int unsigned NLANE = DEF_NLANE,
  parameter int unsigned BW    = DEF_QN + DEF_QM + 1
) ();
  localparam int unsigned PW = aw(NROW / NLANE);
  localparam int unsigned CW = aw(NCOL);

  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [PW-1:0]         pass_idx;
  logic [CW-1:0]         col_addr;
  logic [NLANE*BW-1:0]   w_data;
  logic [BW-1:0]         x_data;
  logic [NROW*BW-1:0]    out_vector;
  logic                  out_valid;
  logic                  sat_flag;

  modport slave (
    input  start, w_data, x_data,
    output busy, done, rd_en, pass_idx, col_addr, out_vector, out_valid, sat_flag
  );

  modport master (
    output start, w_data, x_data,
    input  busy, done, rd_en, pass_idx, col_addr, out_vector, out_valid, sat_flag
  );
endinterface

// File: rtl/mvm_lane.sv
// One signed MAC lane: clear-on-first-column accumulate, floor shift by QM, optional clamp.
// Saturation is enabled by defining MVM_SAT_EN; otherwise the result wraps to BW bits.
module mvm_lane #(
  parameter int unsigned BW    = 18,
  parameter int unsigned QM    = 11,
  parameter int unsigned ACC_W = 38
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_en,
  input  logic                 i_clr,
  input  logic signed [BW-1:0] i_w,
  input  logic signed [BW-1:0] i_x,
  output logic [BW-1:0]        o_res_c,
  output logic                 o_sat_c
);
  logic signed [2*BW-1:0]  w_prod;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod = i_w * i_x;
  assign w_base = i_clr ? '0 : r_acc;
  assign w_sum  = w_base + ACC_W'(w_prod);

`ifdef MVM_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-BW+1){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-BW+1){1'b1}}, {(BW-1){1'b0}}};
  logic signed [ACC_W-1:0] w_shift;

  assign w_shift = w_sum >>> QM;

  always_comb begin
    o_res_c = w_shift[BW-1:0];
    o_sat_c = 1'b0;
    if (w_shift > SAT_MAX) begin
      o_res_c = SAT_MAX[BW-1:0];
      o_sat_c = 1'b1;
    end else if (w_shift < SAT_MIN) begin
      o_res_c = SAT_MIN[BW-1:0];
      o_sat_c = 1'b1;
    end
  end
`else
  // Low BW bits of an arithmetic shift are just a slice of the sum.
  assign o_res_c = w_sum[QM +: BW];
  assign o_sat_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_acc <= '0;
    else if (i_en) r_acc <= w_sum;
  end
endmodule

// File: rtl/mvm_engine.sv
// Matrix-vector multiply y = W*x over NLANE MAC lanes, NROW/NLANE row passes, start/busy/done.
// Optional saturation of each result is enabled by defining MVM_SAT_EN.
module mvm_engine
  import mvm_pkg::*;
#(
  parameter int unsigned NROW  = DEF_NROW,
  parameter int unsigned NCOL  = DEF_NCOL,
  parameter int unsigned NLANE = DEF_NLANE,
  parameter int unsigned QN    = DEF_QN,
  parameter int unsigned QM    = DEF_QM
) (
  input logic  clk,
  input logic  reset,
  mvm_if.slave bus
);
  localparam int unsigned LBW    = QN + QM + 1;
  localparam int unsigned LACC_W = 2 * LBW + clog2(NCOL);
  localparam int unsigned LP     = NROW / NLANE;
  localparam int unsigned LPW    = aw(LP);
  localparam int unsigned LCW    = aw(NCOL);

  logic [1:0]        r_state, w_state_nxt;
  logic              r_busy, r_done, r_rd_en;
  logic              w_busy_nxt, w_done_nxt, w_rd_en_nxt, w_accept;
  logic [LPW-1:0]    r_pass, w_pass_nxt, r_dpass;
  logic [LCW-1:0]    r_col, w_col_nxt, r_dcol;
  logic              r_dv;
  logic [NROW*LBW-1:0] r_out;
  logic              r_out_valid, r_sat;
  logic [LBW-1:0]    w_res [NLANE];
  logic [NLANE-1:0]  w_sat;
  logic              w_last;

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_rd_en_nxt = 1'b0;
    w_pass_nxt  = r_pass;
    w_col_nxt   = r_col;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_RUN;
          w_busy_nxt  = 1'b1;
          w_rd_en_nxt = 1'b1;
          w_pass_nxt  = '0;
          w_col_nxt   = '0;
          w_accept    = 1'b1;
        end
      end
      ST_RUN: begin
        w_busy_nxt  = 1'b1;
        w_rd_en_nxt = 1'b1;
        if (r_col == LCW'(NCOL - 1)) begin
          w_col_nxt = '0;
          if (r_pass == LPW'(LP - 1)) begin
            w_state_nxt = ST_DRAIN;
            w_rd_en_nxt = 1'b0;
            w_pass_nxt  = '0;
          end else begin
            w_pass_nxt = r_pass + LPW'(1);
          end
        end else begin
          w_col_nxt = r_col + LCW'(1);
        end
      end
      ST_DRAIN: begin
        w_state_nxt = ST_DONE;
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b1;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_pass  <= '0;
      r_col   <= '0;
      r_dv    <= 1'b0;
      r_dpass <= '0;
      r_dcol  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_rd_en <= w_rd_en_nxt;
      r_pass  <= w_pass_nxt;
      r_col   <= w_col_nxt;
      r_dv    <= r_rd_en;
      r_dpass <= r_pass;
      r_dcol  <= r_col;
    end
  end

  // Memory data arrives one cycle after the read; r_d* track that read.
  assign w_last = r_dv && (r_dcol == LCW'(NCOL - 1));

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    mvm_lane #(.BW(LBW), .QM(QM), .ACC_W(LACC_W)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_en    (r_dv),
      .i_clr   (r_dcol == '0),
      .i_w     (bus.w_data[i*LBW +: LBW]),
      .i_x     (bus.x_data),
      .o_res_c (w_res[i]),
      .o_sat_c (w_sat[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      if (w_last) begin
        for (int unsigned p = 0; p < LP; p++) begin
          for (int unsigned i = 0; i < NLANE; i++) begin
            if (r_dpass == LPW'(p)) r_out[(p*NLANE+i)*LBW +: LBW] <= w_res[i];
          end
        end
      end
      if (w_accept) r_out_valid <= 1'b0;
      else if (r_state == ST_DONE) r_out_valid <= 1'b1;
      if (w_accept) r_sat <= 1'b0;
      else if (w_last && (|w_sat)) r_sat <= 1'b1;
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.rd_en      = r_rd_en;
  assign bus.pass_idx   = r_pass;
  assign bus.col_addr   = r_col;
  assign bus.out_vector = r_out;
  assign bus.out_valid  = r_out_valid;
  assign bus.sat_flag   = r_sat;
endmodule

// File: doc/mvm_engine.md
# mvm_engine

Parametrised fixed-point matrix-vector multiply engine computing y = W·x for an NROW×NCOL weight matrix and an NCOL-element input vector. It time-multiplexes NLANE parallel MAC lanes over NROW/NLANE row passes, drives read addresses to external weight and vector memories, and presents the full result vector with a start/busy/done handshake. It is the generalised successor of the single-layer dot-product unit in the RNN datapath: arbitrary lane count, explicit handshake, wide accumulators and optional saturation.

## Interface
- NROW, 16, output rows; must be a multiple of NLANE
- NCOL, 4, input vector length; ≥2
- NLANE, 4, parallel MAC lanes
- QN, 6, integer bits (excluding sign)
- QM, 11, fractional bits; BW = QN+QM+1
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin computation; sampled only when busy=0
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when out_vector is complete
- rd_en  out  1  memory read strobe
- pass_idx  out  max(1,clog2(NROW/NLANE))  current row pass (weight address high part)
- col_addr  out  max(1,clog2(NCOL))  current column (weight address low part, vector address)
- w_data  in  NLANE*BW  weights W[pass*NLANE+i][col], lane i at [i*BW +: BW]; valid 1 cycle after rd_en
- x_data  in  BW  x[col]; valid 1 cycle after rd_en
- out_vector  out  NROW*BW  y, row r at [r*BW +: BW]
- out_valid  out  1  out_vector holds a complete result
- sat_flag  out  1  sticky: any row saturated in last computation

## Operation
- P = NROW/NLANE. States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 → RUN, pass_idx=0, col_addr=0, out_valid←0, sat_flag←0.
- RUN: rd_en=1 every cycle; col_addr increments, wraps NCOL-1→0 with pass_idx+1. After issuing (P-1, NCOL-1) → DRAIN.
- Datapath, one cycle after each read: lane i acc ← (col==0 ? 0 : acc) + w_i·x, signed. ACC_W = 2*BW + clog2(NCOL); no overflow possible in acc.
- When the product for col NCOL-1 is accumulated, lane i result = (acc_final >>> QM) (arithmetic shift, floor) is written to row pass*NLANE+i of out_vector in that cycle.
- DRAIN: one cycle, last pass written. DONE: done=1, out_valid←1 → IDLE.
- start while busy=1: ignored, no queuing. start held high in DONE/IDLE: a new computation starts immediately from IDLE.
- Reset anytime: state IDLE, all outputs 0 (busy, done, rd_en, pass_idx, col_addr, out_vector, out_valid, sat_flag); accumulators cleared.

## Timing
- start sampled at edge T; rd_en first high in cycle T+1 (col 0, pass 0).
- rd_en high exactly P*NCOL consecutive cycles.
- done high in cycle T+P*NCOL+2; out_vector stable and out_valid=1 from T+P*NCOL+3 until next accepted start.
- Rows of pass p update in cycle T+(p+1)*NCOL+1; out_vector is not coherent before done.
- Back-to-back: start held high gives next rd_en at T+P*NCOL+4.

## Configuration
- MVM_SAT_EN defined: shifted result clamped to [-2^(BW-1), 2^(BW-1)-1]; any clamp sets sat_flag (sticky until next start).
- Undefined: result truncated to low BW bits (two's-complement wrap); sat_flag tied 0.

## Structure
- Package mvm_pkg: state enum, clog2 helper, derived width constants (BW, ACC_W, P, address widths).
- Sub-module mvm_lane: one signed MAC with clear-on-col-0, shift by QM, optional saturation, sat output; instantiated NLANE times by generate.

## Test plan
- Defaults, W=identity-like (W[r][r mod 4]=1.0=2048), x={1.0,2.0,-1.0,0.5} → y[r]=x[r mod 4] in Q6.11, done at T+18.
- All W=x=max (131071) with MVM_SAT_EN → every row 131071, sat_flag=1; without macro → wrapped low 18 bits, sat_flag=0.
- W all -1 LSB, x all +1 LSB → acc=-4, y=-1 (floor) for every row.
- start pulsed again at T+5 during RUN → ignored; single done at T+18, results unchanged.
- reset asserted at T+7 → next cycle all outputs 0, IDLE; new start gives correct result.
- NROW=NLANE=8, NCOL=3 (single pass, non-power-of-2 columns) → col_addr 0,1,2 then done at T+5, matches reference model.
